mc_fir: RTL and testbench
=========================

MC_FIR -- requirements
Module: mc_fir

Interface
REQ-001 SHALL have parameter TAP, default 32, filter length in taps (>=2).
REQ-002 SHALL have parameter NCH, default 4, number of independent time-multiplexed channels (>=1).
REQ-003 SHALL have parameter DIM_DATA, default 16, signed sample width.
REQ-004 SHALL have parameter DIM_COEFF, default 16, signed coefficient width.
REQ-005 SHALL have parameter DIM_ACC, default 40, signed accumulator width (>= DIM_DATA+DIM_COEFF+clog2(TAP)).
REQ-006 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports cfg_we  in  1, cfg_addr  in  clog2(TAP), cfg_data  in  DIM_COEFF: coefficient write strobe, tap index, value.
REQ-009 SHALL have port cfg_shift  in  6  output arithmetic right-shift amount, sampled at s handshake.
REQ-010 SHALL have port clr  in  1  one-cycle request to zero all channel histories.
REQ-011 SHALL have ports s_valid  in  1, s_ready  out  1, s_ch  in  clog2(NCH), s_data  in  DIM_DATA: input sample stream.
REQ-012 SHALL have ports m_valid  out  1, m_ready  in  1, m_ch  out  clog2(NCH), m_data  out  DIM_DATA, m_sat  out  1: output stream.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states CLEAR, IDLE, MAC, OUT.
REQ-015 SHALL, in CLEAR, zero one history location per cycle over NCH*TAP cycles, reset all channel write pointers to 0, then enter IDLE.
REQ-016 SHALL assert s_ready only in IDLE when cfg_we=0 and clr=0.
REQ-017 SHALL, on s handshake (cycle T), write s_data at the channel's circular pointer, latch s_ch and cfg_shift, clear the accumulator, and enter MAC.
REQ-018 SHALL, in MAC, accumulate coeff[k]*x_ch[n-k] for k=0..TAP-1, one product per cycle, history index wrapping modulo TAP.
REQ-019 SHALL assert m_valid at cycle T+TAP+2 (fixed latency including one MAC pipeline stage), entering OUT.
REQ-020 SHALL compute m_data = acc >>> shift saturated to [-2^(DIM_DATA-1), 2^(DIM_DATA-1)-1], with m_sat=1 exactly when clipping occurred.
REQ-021 SHALL hold m_valid, m_ch, m_data, m_sat stable while m_valid=1 and m_ready=0.
REQ-022 SHALL, on m handshake, advance the channel pointer modulo TAP and return to IDLE the next cycle.
REQ-023 SHALL accept cfg_we only in IDLE; cfg_we in any other state SHALL be ignored.
REQ-024 SHALL give cfg_we priority over s_valid in IDLE (s_ready=0 that cycle; sample not consumed).
REQ-025 SHALL honour clr only in IDLE (entering CLEAR); clr elsewhere SHALL be ignored.
REQ-026 SHALL consume and discard samples with s_ch >= NCH, producing no output and leaving all histories unchanged.
REQ-027 SHALL share one coefficient bank across all channels; coefficients SHALL survive clr.

Reset
REQ-028 SHALL, on rst, enter CLEAR, drive s_ready=0, m_valid=0, m_ch=0, m_data=0, m_sat=0, busy=1, regardless of the current state (including mid-MAC or OUT).
REQ-029 SHALL reset all coefficients to 0.

Structure
REQ-030 SHALL place state encoding and a default-width constant set in package mc_fir_pkg.
REQ-031 SHALL use one sub-module mc_fir_mac: registered multiply, accumulate with clear, and shift/saturate stage.
REQ-032 SHALL hold histories in a single NCH*TAP-entry memory indexed {ch, ptr}.

Verification (TAP=4, NCH=2, DIM_DATA=DIM_COEFF=16, DIM_ACC=40)
REQ-033 SHALL cover impulse: coeffs {1,2,3,4}, shift 0, ch0 inputs 1,0,0,0 -> m_data 1,2,3,4, m_sat=0, each at T+6.
REQ-034 SHALL cover isolation: ch0 impulse interleaved with ch1 inputs 0 -> ch1 outputs all 0, ch0 outputs 1,2,3,4.
REQ-035 SHALL cover saturation: coeffs all 32767, four inputs 32767, shift 0 -> 32767, m_sat=1; inputs -32768 -> -32768, m_sat=1.
REQ-036 SHALL cover backpressure: m_ready=0 for 10 cycles -> outputs stable, s_ready=0, busy=1 throughout.
REQ-037 SHALL cover rst asserted during MAC -> m_valid=0 next cycle, s_ready=0 for 8 CLEAR cycles, then impulse yields 1,2,3,4 with no stale history.
REQ-038 SHALL cover cfg_we and s_valid together in IDLE -> coefficient written, sample accepted the following cycle.

Source files
------------

// File: rtl/mc_fir_pkg.sv
// Shared definitions for the multi-channel FIR: controller state encoding,
// default parameter values and the output-shift field width.
package mc_fir_pkg;

  localparam int unsigned DEF_TAP       = 32;
  localparam int unsigned DEF_NCH       = 4;
  localparam int unsigned DEF_DIM_DATA  = 16;
  localparam int unsigned DEF_DIM_COEFF = 16;
  localparam int unsigned DEF_DIM_ACC   = 40;
  localparam int unsigned SHIFT_W       = 6;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MAC   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/mc_fir_mac.sv
// Multiply-accumulate datapath for mc_fir.
//   clk, rst      : clock, synchronous active-high reset
//   acc_clr       : zero the accumulator (start of a new output)
//   mul_en        : register coeff*sample into the product stage
//   acc_en        : add the registered product into the accumulator
//   coeff, sample : signed operands
//   shift         : arithmetic right shift applied to the running sum
//   res_c, sat_c  : shifted/saturated (acc + product) and clip flag
module mc_fir_mac
  import mc_fir_pkg::*;
#(
  parameter int unsigned DIM_DATA  = DEF_DIM_DATA,
  parameter int unsigned DIM_COEFF = DEF_DIM_COEFF,
  parameter int unsigned DIM_ACC   = DEF_DIM_ACC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_clr,
  input  logic                 mul_en,
  input  logic                 acc_en,
  input  logic [DIM_COEFF-1:0] coeff,
  input  logic [DIM_DATA-1:0]  sample,
  input  logic [SHIFT_W-1:0]   shift,
  output logic [DIM_DATA-1:0]  res_c,
  output logic                 sat_c
);

  localparam int unsigned PW = DIM_DATA + DIM_COEFF;
  localparam logic signed [DIM_ACC-1:0] MAX_V =
    {{(DIM_ACC - DIM_DATA + 1){1'b0}}, {(DIM_DATA - 1){1'b1}}};
  localparam logic signed [DIM_ACC-1:0] MIN_V = ~MAX_V;

  logic signed [PW-1:0]      prod;
  logic signed [DIM_ACC-1:0] acc;
  logic signed [DIM_ACC-1:0] sum_c;
  logic signed [DIM_ACC-1:0] shifted_c;

  // Product pipeline stage and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (mul_en) prod <= PW'($signed(coeff)) * PW'($signed(sample));
      if (acc_clr)     acc <= '0;
      else if (acc_en) acc <= sum_c;
    end
  end

  // The final tap's product is folded in here so the result is ready on the last MAC cycle
  assign sum_c     = acc + DIM_ACC'(prod);
  assign shifted_c = sum_c >>> shift;

  // Clip to the signed output range
  always_comb begin
    res_c = shifted_c[DIM_DATA-1:0];
    sat_c = 1'b0;
    if (shifted_c > MAX_V) begin
      res_c = MAX_V[DIM_DATA-1:0];
      sat_c = 1'b1;
    end else if (shifted_c < MIN_V) begin
      res_c = MIN_V[DIM_DATA-1:0];
      sat_c = 1'b1;
    end
  end

endmodule

// File: rtl/mc_fir.sv
// Time-multiplexed multi-channel FIR filter with a shared coefficient bank.
//   clk, rst                   : clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data   : coefficient write (honoured in IDLE only)
//   cfg_shift                  : output right shift, latched with each sample
//   clr                        : zero all channel histories (IDLE only)
//   s_valid/s_ready/s_ch/s_data: input sample stream
//   m_valid/m_ready/m_ch/m_data/m_sat : output stream, m_sat flags clipping
//   busy                       : controller not in IDLE
module mc_fir
  import mc_fir_pkg::*;
#(
  parameter int unsigned TAP       = DEF_TAP,
  parameter int unsigned NCH       = DEF_NCH,
  parameter int unsigned DIM_DATA  = DEF_DIM_DATA,
  parameter int unsigned DIM_COEFF = DEF_DIM_COEFF,
  parameter int unsigned DIM_ACC   = DEF_DIM_ACC,
  localparam int unsigned TAP_W    = $clog2(TAP),
  localparam int unsigned CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [TAP_W-1:0]     cfg_addr,
  input  logic [DIM_COEFF-1:0] cfg_data,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  input  logic                 clr,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CH_W-1:0]      s_ch,
  input  logic [DIM_DATA-1:0]  s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CH_W-1:0]      m_ch,
  output logic [DIM_DATA-1:0]  m_data,
  output logic                 m_sat,
  output logic                 busy
);

  localparam int unsigned DEPTH = NCH * TAP;
  localparam int unsigned HA_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(TAP + 1);
  localparam int unsigned CLR_W = $clog2(DEPTH + 1);

  state_t               state;
  logic [DIM_COEFF-1:0] coeff   [TAP];
  logic [DIM_DATA-1:0]  hist    [DEPTH];
  logic [TAP_W-1:0]     wr_ptr  [NCH];
  logic [CH_W-1:0]      cur_ch;
  logic [SHIFT_W-1:0]   cur_shift;
  logic [TAP_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     mac_cnt;
  logic [CLR_W-1:0]     clr_cnt;

  logic                 s_fire_c;
  logic                 ch_ok_c;
  logic                 mul_en_c;
  logic                 acc_en_c;
  logic [HA_W-1:0]      wr_addr_c;
  logic [HA_W-1:0]      rd_addr_c;
  logic [DIM_DATA-1:0]  res_c;
  logic                 sat_c;

  assign s_ready  = (state == ST_IDLE) && !cfg_we && !clr;
  assign busy     = (state != ST_IDLE);
  assign s_fire_c = s_valid && s_ready;
  assign ch_ok_c  = 32'(s_ch) < NCH;

  // History is laid out channel-major: entry = ch*TAP + ptr
  assign wr_addr_c = HA_W'(32'(s_ch) * TAP + 32'(wr_ptr[s_ch]));
  assign rd_addr_c = HA_W'(32'(cur_ch) * TAP + 32'(rd_ptr));

  // Products are issued for mac_cnt 0..TAP-1; accumulation lags by one cycle
  assign mul_en_c = (state == ST_MAC) && (32'(mac_cnt) < TAP);
  assign acc_en_c = (state == ST_MAC) && (mac_cnt != '0);

  mc_fir_mac #(
    .DIM_DATA (DIM_DATA),
    .DIM_COEFF(DIM_COEFF),
    .DIM_ACC  (DIM_ACC)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .acc_clr(s_fire_c),
    .mul_en (mul_en_c),
    .acc_en (acc_en_c),
    .coeff  (coeff[TAP_W'(mac_cnt)]),
    .sample (hist[rd_addr_c]),
    .shift  (cur_shift),
    .res_c  (res_c),
    .sat_c  (sat_c)
  );

  // Controller, coefficient bank, history memory and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      mac_cnt   <= '0;
      rd_ptr    <= '0;
      cur_ch    <= '0;
      cur_shift <= '0;
      m_valid   <= 1'b0;
      m_ch      <= '0;
      m_data    <= '0;
      m_sat     <= 1'b0;
      for (int i = 0; i < TAP; i++) coeff[i] <= '0;
      for (int i = 0; i < NCH; i++) wr_ptr[i] <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          hist[HA_W'(clr_cnt)] <= '0;
          for (int i = 0; i < NCH; i++) wr_ptr[i] <= '0;
          if (clr_cnt == CLR_W'(DEPTH - 1)) begin
            clr_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end
        ST_IDLE: begin
          if (cfg_we && (32'(cfg_addr) < TAP)) coeff[cfg_addr] <= cfg_data;
          if (clr) begin
            clr_cnt <= '0;
            state   <= ST_CLEAR;
          end else if (s_fire_c && ch_ok_c) begin
            // Out-of-range channels are handshaken but otherwise dropped
            hist[wr_addr_c] <= s_data;
            cur_ch          <= s_ch;
            cur_shift       <= cfg_shift;
            rd_ptr          <= wr_ptr[s_ch];
            mac_cnt         <= '0;
            state           <= ST_MAC;
          end
        end
        ST_MAC: begin
          rd_ptr <= (rd_ptr == '0) ? TAP_W'(TAP - 1) : rd_ptr - TAP_W'(1);
          if (mac_cnt == CNT_W'(TAP)) begin
            m_valid <= 1'b1;
            m_ch    <= cur_ch;
            m_data  <= res_c;
            m_sat   <= sat_c;
            state   <= ST_OUT;
          end else begin
            mac_cnt <= mac_cnt + CNT_W'(1);
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid        <= 1'b0;
            wr_ptr[cur_ch] <= (32'(wr_ptr[cur_ch]) == TAP - 1) ? '0
                              : wr_ptr[cur_ch] + TAP_W'(1);
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_fir.sv
// Self-checking bench for mc_fir (TAP=4, NCH=2, 16-bit data/coefficients).
module tb_mc_fir;

  localparam int TAP = 4;
  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic [5:0]  cfg_shift = '0;
  logic        clr = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [0:0]  s_ch = '0;
  logic [15:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [0:0]  m_ch;
  logic [15:0] m_data;
  logic        m_sat;
  logic        busy;

  mc_fir #(
    .TAP(TAP), .NCH(NCH), .DIM_DATA(16), .DIM_COEFF(16), .DIM_ACC(40)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_shift(cfg_shift), .clr(clr), .s_valid(s_valid), .s_ready(s_ready),
    .s_ch(s_ch), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_ch(m_ch), .m_data(m_data), .m_sat(m_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-channel sample list since the last clear, direct-form sum
  int coef_m [TAP];
  int hist_m [NCH][$];

  function automatic void model_push(input int ch, input int x);
    hist_m[ch].push_back(x);
  endfunction

  function automatic void model_out(input int ch, input int sh, output int y, output bit sat);
    longint acc;
    int idx;
    acc = 0;
    for (int k = 0; k < TAP; k++) begin
      idx = hist_m[ch].size() - 1 - k;
      if (idx >= 0) acc += longint'(coef_m[k]) * longint'(hist_m[ch][idx]);
    end
    acc = acc >>> sh;
    y   = int'(acc);
    sat = 1'b0;
    if (acc > 32767) begin y = 32767; sat = 1'b1; end
    else if (acc < -32768) begin y = -32768; sat = 1'b1; end
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NCH; c++) hist_m[c].delete();
  endfunction

  task automatic write_coeff(input int addr, input int val);
    cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_data = 16'(val);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    coef_m[addr] = val;
  endtask

  task automatic do_clr();
    int n;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n = 0;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    model_clear();
  endtask

  // Drives one sample and collects its result; lat counts cycles from handshake to m_valid
  task automatic do_sample(input int ch, input int x, input int sh, input bit disturb,
                           output logic [15:0] d, output logic s, output logic c, output int lat);
    int n;
    s_valid = 1'b1; s_ch = 1'(ch); s_data = 16'(x); cfg_shift = 6'(sh);
    #1;
    n = 0;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    lat = -1;
    if (s_ready) begin
      @(posedge clk); #1;
      s_valid = 1'b0;
      cfg_shift = 6'($urandom);
      if (disturb) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 16'h1234; clr = 1'b1; end
      lat = 1;
      while (!m_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    end
    s_valid = 1'b0;
    d = m_data; s = m_sat; c = m_ch;
    if (m_valid) begin m_ready = 1'b1; @(posedge clk); #1; m_ready = 1'b0; end
    cfg_we = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {s_ready, busy, m_valid, m_sat, m_ch, m_data};
    n_cmp++;
    if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      n_bad++; $display("FAIL reset_outputs: got %h want %h", got, {1'b0, 1'b1, 19'h0});
    end
    rst = 1'b0;
    n = 0;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (n !== NCH * TAP) begin n_bad++; $display("FAIL reset_clear_cycles: got %0d want %0d", n, NCH * TAP); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    model_clear();
    for (int k = 0; k < TAP; k++) coef_m[k] = 0;
  endtask

  task automatic test_impulse();
    logic [15:0] d; logic s; logic c; int lat;
    for (int k = 0; k < TAP; k++) write_coeff(k, k + 1);
    for (int i = 0; i < TAP; i++) begin
      model_push(0, (i == 0) ? 1 : 0);
      do_sample(0, (i == 0) ? 1 : 0, 0, 1'b0, d, s, c, lat);
      n_cmp++;
      if (d !== 16'(i + 1) || s !== 1'b0) begin
        n_bad++; $display("FAIL impulse[%0d]: got data %0d sat %b want data %0d sat 0", i, $signed(d), s, i + 1);
      end
      n_cmp++;
      if (lat !== TAP + 2) begin n_bad++; $display("FAIL impulse_latency[%0d]: got %0d want %0d", i, lat, TAP + 2); end
    end
  endtask

  task automatic test_isolation();
    logic [15:0] d; logic s; logic c; int lat;
    do_clr();
    for (int i = 0; i < TAP; i++) begin
      model_push(0, (i == 0) ? 1 : 0);
      do_sample(0, (i == 0) ? 1 : 0, 0, 1'b0, d, s, c, lat);
      n_cmp++;
      if (d !== 16'(i + 1) || c !== 1'b0) begin
        n_bad++; $display("FAIL iso_ch0[%0d]: got data %0d ch %b want data %0d ch 0", i, $signed(d), c, i + 1);
      end
      model_push(1, 0);
      do_sample(1, 0, 0, 1'b0, d, s, c, lat);
      n_cmp++;
      if (d !== 16'd0 || c !== 1'b1) begin
        n_bad++; $display("FAIL iso_ch1[%0d]: got data %0d ch %b want data 0 ch 1", i, $signed(d), c);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] d; logic s; logic c; int lat; int ey; bit es;
    for (int k = 0; k < TAP; k++) write_coeff(k, 32767);
    do_clr();
    for (int i = 0; i < 2 * TAP; i++) begin
      int x;
      x = (i < TAP) ? 32767 : -32768;
      model_push(0, x);
      model_out(0, 0, ey, es);
      do_sample(0, x, 0, 1'b0, d, s, c, lat);
      n_cmp++;
      if (d !== 16'(ey) || s !== es) begin
        n_bad++; $display("FAIL sat[%0d]: got data %0d sat %b want data %0d sat %b", i, $signed(d), s, ey, es);
      end
      if (i == TAP - 1 || i == 2 * TAP - 1) begin
        n_cmp++;
        if (d !== ((i < TAP) ? 16'h7FFF : 16'h8000) || s !== 1'b1) begin
          n_bad++; $display("FAIL sat_final[%0d]: got data %0d sat %b want clipped sat 1", i, $signed(d), s);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] snap, now;
    int n; int ey; bit es;
    for (int k = 0; k < TAP; k++) write_coeff(k, k + 1);
    do_clr();
    model_push(1, 3);
    model_out(1, 0, ey, es);
    s_valid = 1'b1; s_ch = 1'b1; s_data = 16'd3; cfg_shift = 6'd0;
    #1;
    n = 0;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_ch = 1'b0; s_data = 16'h0077;
    n = 1;
    while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
    snap = {m_valid, m_ch, m_sat, m_data};
    n_cmp++;
    if (snap !== {1'b1, 1'b1, 1'(es), 16'(ey)}) begin
      n_bad++; $display("FAIL bp_first: got %h want %h", snap, {1'b1, 1'b1, 1'(es), 16'(ey)});
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      now = {m_valid, m_ch, m_sat, m_data};
      n_cmp++;
      if (now !== snap || s_ready !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got out %h s_ready %b busy %b want out %h s_ready 0 busy 1", i, now, s_ready, busy, snap);
      end
    end
    s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: got m_valid %b busy %b want 0 0", m_valid, busy);
    end
  endtask

  task automatic test_ignore();
    logic [15:0] d; logic s; logic c; int lat; int ey; bit es;
    do_clr();
    for (int i = 1; i <= 3; i++) begin
      model_push(0, i);
      model_out(0, 0, ey, es);
      do_sample(0, i, 0, i != 3, d, s, c, lat);
      n_cmp++;
      if (d !== 16'(ey) || s !== es) begin
        n_bad++; $display("FAIL ignore[%0d]: got data %0d sat %b want data %0d sat %b", i, $signed(d), s, ey, es);
      end
    end
    n_cmp++;
    if (d !== 16'd10) begin n_bad++; $display("FAIL ignore_final: got %0d want 10", $signed(d)); end
  endtask

  task automatic test_collision();
    int n; int ey; bit es;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 16'd5;
    s_valid = 1'b1; s_ch = 1'b0; s_data = 16'd2; cfg_shift = 6'd0;
    #1;
    n_cmp++;
    if (s_ready !== 1'b0) begin n_bad++; $display("FAIL coll_ready_we: got %b want 0", s_ready); end
    @(posedge clk); #1;
    cfg_we = 1'b0; coef_m[0] = 5;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL coll_ready_next: got %b want 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    model_push(0, 2);
    model_out(0, 0, ey, es);
    n = 1;
    while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (n !== TAP + 2 || m_data !== 16'(ey)) begin
      n_bad++; $display("FAIL coll_result: got lat %0d data %0d want lat %0d data %0d", n, $signed(m_data), TAP + 2, ey);
    end
    m_ready = 1'b1; @(posedge clk); #1; m_ready = 1'b0;
  endtask

  task automatic test_rst_mid_mac();
    logic [15:0] d; logic s; logic c; int lat; int n;
    do_sample(0, 7, 0, 1'b0, d, s, c, lat);
    do_sample(0, 9, 0, 1'b0, d, s, c, lat);
    s_valid = 1'b1; s_ch = 1'b0; s_data = 16'd11; cfg_shift = 6'd0;
    #1;
    n = 0;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL rst_mac_outputs: got m_valid %b s_ready %b busy %b want 0 0 1", m_valid, s_ready, busy);
    end
    n = 0;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (n !== NCH * TAP) begin n_bad++; $display("FAIL rst_mac_clear_cycles: got %0d want %0d", n, NCH * TAP); end
    model_clear();
    for (int k = 0; k < TAP; k++) coef_m[k] = 0;
    model_push(1, 5);
    do_sample(1, 5, 0, 1'b0, d, s, c, lat);
    n_cmp++;
    if (d !== 16'd0) begin n_bad++; $display("FAIL rst_coeff_zero: got %0d want 0", $signed(d)); end
    for (int k = 0; k < TAP; k++) write_coeff(k, k + 1);
    for (int i = 0; i < TAP; i++) begin
      model_push(0, (i == 0) ? 1 : 0);
      do_sample(0, (i == 0) ? 1 : 0, 0, 1'b0, d, s, c, lat);
      n_cmp++;
      if (d !== 16'(i + 1) || s !== 1'b0) begin
        n_bad++; $display("FAIL rst_impulse[%0d]: got data %0d sat %b want data %0d sat 0", i, $signed(d), s, i + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] d; logic s; logic c; int lat; int ey; bit es;
    int ch, x, sh;
    do_clr();
    for (int k = 0; k < TAP; k++) write_coeff(k, int'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < 40; i++) begin
      ch = int'($urandom_range(0, NCH - 1));
      x  = int'($urandom_range(0, 65535)) - 32768;
      sh = int'($urandom_range(0, 20));
      model_push(ch, x);
      model_out(ch, sh, ey, es);
      do_sample(ch, x, sh, 1'($urandom_range(0, 1)), d, s, c, lat);
      n_cmp++;
      if (d !== 16'(ey) || s !== es || c !== 1'(ch)) begin
        n_bad++; $display("FAIL random[%0d]: got data %0d sat %b ch %b want data %0d sat %b ch %0d", i, $signed(d), s, c, ey, es, ch);
      end
      n_cmp++;
      if (lat !== TAP + 2) begin n_bad++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, TAP + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_isolation();
    test_saturation();
    test_backpressure();
    test_ignore();
    test_collision();
    test_rst_mid_mac();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
